// File: rtl/ofdm_pkg.sv
// Shared OFDM framing constants and cyclic-prefix FSM encoding.
// Used by both the add and remove cyclic-prefix blocks.
package ofdm_pkg;

  localparam int N_FFT    = 64;
  localparam int N_CP     = 16;
  localparam int CP_WIDTH = 20;
  localparam int POS_W    = 7;
  localparam int IDX_W    = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP_CP = 2'd1,
    PASS    = 2'd2
  } cp_state_e;

endpackage

// File: rtl/cp_pos_counter.sv
// Sample position counter within one OFDM symbol.
// Wraps after the last sample; clear drops a truncated symbol.
module cp_pos_counter #(
  parameter int SYM_LEN = ofdm_pkg::N_CP + ofdm_pkg::N_FFT
) (
  input  logic                      cp_clk,
  input  logic                      cp_rst_n,
  input  logic                      inc,
  input  logic                      clr,
  output logic [ofdm_pkg::POS_W-1:0] pos,
  output logic                      last
);
  import ofdm_pkg::*;

  localparam logic [POS_W-1:0] LAST = POS_W'(SYM_LEN - 1);

  assign last = (pos == LAST);

  always_ff @(posedge cp_clk or negedge cp_rst_n) begin
    if (!cp_rst_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (inc) begin
      pos <= last ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/remove_cyclic_prefix.sv
// Strips the cyclic prefix from each received OFDM symbol.
// Useful samples leave one cycle later, tagged with their index.
module remove_cyclic_prefix #(
  parameter int WIDTH = ofdm_pkg::CP_WIDTH,
  parameter int N_FFT = ofdm_pkg::N_FFT,
  parameter int N_CP  = ofdm_pkg::N_CP
) (
  input  logic             cp_clk,
  input  logic             cp_rst_n,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] cp_real_din,
  input  logic [WIDTH-1:0] cp_imag_din,
  output logic [WIDTH-1:0] cp_real_dout,
  output logic [WIDTH-1:0] cp_imag_dout,
  output logic             dout_valid,
  output logic [5:0]       dout_index,
  output logic             dout_sof,
  output logic             sym_err
);
  import ofdm_pkg::*;

  localparam logic [POS_W-1:0] CP_LAST = POS_W'(N_CP - 1);
  localparam logic [POS_W-1:0] CP_LEN  = POS_W'(N_CP);

  cp_state_e        state_q;
  cp_state_e        state_d;
  logic [POS_W-1:0] pos;
  logic             last;
  logic             inc;
  logic             clr;
  logic             trunc;
  logic             pass;
  logic [IDX_W-1:0] idx;

  cp_pos_counter #(
    .SYM_LEN (N_CP + N_FFT)
  ) u_pos (
    .cp_clk   (cp_clk),
    .cp_rst_n (cp_rst_n),
    .inc      (inc),
    .clr      (clr),
    .pos      (pos),
    .last     (last)
  );

  assign idx = IDX_W'(pos - CP_LEN);

  always_ff @(posedge cp_clk or negedge cp_rst_n) begin
    if (!cp_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    clr     = 1'b0;
    trunc   = 1'b0;
    pass    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          inc     = 1'b1;
          state_d = SKIP_CP;
        end
      end
      SKIP_CP: begin
        if (din_valid) begin
          inc = 1'b1;
          if (pos == CP_LAST) begin
            state_d = PASS;
          end
        end else begin
          trunc   = 1'b1;
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      PASS: begin
        if (din_valid) begin
          inc  = 1'b1;
          pass = 1'b1;
          // After the last sample IDLE takes the next one with no gap
          if (last) begin
            state_d = IDLE;
          end
        end else begin
          trunc   = 1'b1;
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge cp_clk or negedge cp_rst_n) begin
    if (!cp_rst_n) begin
      cp_real_dout <= '0;
      cp_imag_dout <= '0;
      dout_valid   <= 1'b0;
      dout_index   <= '0;
      dout_sof     <= 1'b0;
      sym_err      <= 1'b0;
    end else begin
      cp_real_dout <= pass ? cp_real_din : '0;
      cp_imag_dout <= pass ? cp_imag_din : '0;
      dout_valid   <= pass;
      dout_index   <= pass ? idx : '0;
      dout_sof     <= pass && (idx == '0);
      sym_err      <= trunc;
    end
  end

endmodule

// File: tb/tb_remove_cyclic_prefix.sv
// Directed bench for remove_cyclic_prefix.
// Samples carry real=pos, imag=-pos so each output names its source.
module tb_remove_cyclic_prefix;

  localparam int W = 20;

  logic         cp_clk = 1'b0;
  logic         cp_rst_n = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] cp_real_din = '0;
  logic [W-1:0] cp_imag_din = '0;
  logic [W-1:0] cp_real_dout;
  logic [W-1:0] cp_imag_dout;
  logic         dout_valid;
  logic [5:0]   dout_index;
  logic         dout_sof;
  logic         sym_err;

  int n_chk = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_sof = 0;
  int n_err = 0;

  always #5 cp_clk = ~cp_clk;

  remove_cyclic_prefix #(
    .WIDTH (W),
    .N_FFT (64),
    .N_CP  (16)
  ) dut (
    .cp_clk       (cp_clk),
    .cp_rst_n     (cp_rst_n),
    .din_valid    (din_valid),
    .cp_real_din  (cp_real_din),
    .cp_imag_din  (cp_imag_din),
    .cp_real_dout (cp_real_dout),
    .cp_imag_dout (cp_imag_dout),
    .dout_valid   (dout_valid),
    .dout_index   (dout_index),
    .dout_sof     (dout_sof),
    .sym_err      (sym_err)
  );

  task automatic step(input logic v, input int p);
    @(negedge cp_clk);
    din_valid   = v;
    cp_real_din = v ? W'(p) : '0;
    cp_imag_din = v ? W'(-p) : '0;
    @(posedge cp_clk);
    #1;
    if (dout_valid) n_out++;
    if (dout_sof) n_sof++;
    if (sym_err) n_err++;
  endtask

  task automatic clear_counts();
    n_out = 0;
    n_sof = 0;
    n_err = 0;
  endtask

  task automatic drive_sym(input int n);
    for (int p = 0; p < n; p++) begin
      logic       ev;
      logic [W-1:0] er;
      logic [W-1:0] ei;
      logic [5:0] ex;
      step(1'b1, p);
      ev = (p >= 16);
      er = ev ? W'(p) : '0;
      ei = ev ? W'(-p) : '0;
      ex = ev ? 6'(p - 16) : 6'd0;
      n_chk++;
      if (dout_valid !== ev || cp_real_dout !== er ||
          cp_imag_dout !== ei || dout_index !== ex ||
          dout_sof !== (p == 16) || sym_err !== 1'b0) begin
        n_bad++;
        $display("FAIL sym_pos%0d: v=%b re=%h im=%h idx=%0d sof=%b err=%b want v=%b re=%h im=%h idx=%0d sof=%b err=0",
                 p, dout_valid, cp_real_dout, cp_imag_dout, dout_index,
                 dout_sof, sym_err, ev, er, ei, ex, (p == 16));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 0);
      n_chk++;
      if (dout_valid !== 1'b0 || cp_real_dout !== '0 ||
          cp_imag_dout !== '0 || dout_index !== '0 ||
          dout_sof !== 1'b0 || sym_err !== 1'b0) begin
        n_bad++;
        $display("FAIL idle: v=%b re=%h im=%h idx=%0d sof=%b err=%b want all 0",
                 dout_valid, cp_real_dout, cp_imag_dout, dout_index,
                 dout_sof, sym_err);
      end
    end
  endtask

  task automatic check_counts(input string nm, input int eo,
                              input int es, input int ee);
    n_chk++;
    if (n_out !== eo || n_sof !== es || n_err !== ee) begin
      n_bad++;
      $display("FAIL %s: outs=%0d sofs=%0d errs=%0d want %0d %0d %0d",
               nm, n_out, n_sof, n_err, eo, es, ee);
    end
  endtask

  task automatic expect_err(input string nm);
    step(1'b0, 0);
    n_chk++;
    if (sym_err !== 1'b1 || dout_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: sym_err=%b dout_valid=%b want 1 0",
               nm, sym_err, dout_valid);
    end
  endtask

  task automatic test_reset();
    cp_rst_n = 1'b0;
    repeat (3) @(posedge cp_clk);
    #1;
    n_chk++;
    if (dout_valid !== 1'b0 || cp_real_dout !== '0 ||
        cp_imag_dout !== '0 || dout_index !== '0 ||
        dout_sof !== 1'b0 || sym_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: v=%b re=%h im=%h idx=%0d sof=%b err=%b want all 0",
               dout_valid, cp_real_dout, cp_imag_dout, dout_index,
               dout_sof, sym_err);
    end
    @(negedge cp_clk);
    cp_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    clear_counts();
    drive_sym(80);
    idle(1);
    check_counts("single", 64, 1, 0);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    drive_sym(80);
    drive_sym(80);
    drive_sym(80);
    idle(2);
    check_counts("back_to_back", 192, 3, 0);
  endtask

  task automatic test_gap();
    clear_counts();
    drive_sym(80);
    idle(16);
    drive_sym(80);
    idle(16);
    check_counts("gap", 128, 2, 0);
  endtask

  task automatic test_trunc_pass();
    clear_counts();
    drive_sym(40);
    expect_err("trunc40_err");
    idle(3);
    check_counts("trunc40", 24, 1, 1);
    clear_counts();
    drive_sym(80);
    idle(1);
    check_counts("after_trunc40", 64, 1, 0);
  endtask

  task automatic test_trunc_cp();
    clear_counts();
    drive_sym(10);
    expect_err("trunc10_err");
    idle(3);
    check_counts("trunc10", 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    clear_counts();
    drive_sym(50);
    @(negedge cp_clk);
    din_valid = 1'b0;
    cp_rst_n  = 1'b0;
    #1;
    n_chk++;
    if (dout_valid !== 1'b0 || cp_real_dout !== '0 ||
        dout_index !== '0 || sym_err !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: v=%b re=%h idx=%0d err=%b want 0",
               dout_valid, cp_real_dout, dout_index, sym_err);
    end
    repeat (2) @(posedge cp_clk);
    @(negedge cp_clk);
    cp_rst_n = 1'b1;
    idle(2);
    check_counts("reset_mid", 34, 1, 0);
    clear_counts();
    drive_sym(80);
    idle(1);
    check_counts("after_reset", 64, 1, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_trunc_pass();
    test_trunc_cp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
